// File: rtl/seq_pkg.sv
// seq_pkg: shared types and defaults for the seq_gen / seq_check pair.
package seq_pkg;
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
    localparam int DEF_PAT_W = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b0110;
    localparam logic DEF_IDLE_LVL = 1'b1;
endpackage

// File: rtl/seq_gen_if.sv
// seq_gen_if: control and serial-line bundle between a burst requester and seq_gen.
interface seq_gen_if #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] reps;
    logic [GAP_W-1:0] gap;
    logic             data;
    logic             valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] reps_left;
    modport master (output start, abort, reps, gap, input data, valid, busy, done, reps_left);
    modport slave (input start, abort, reps, gap, output data, valid, busy, done, reps_left);
endinterface

// File: rtl/seq_gen_cnt.sv
// seq_gen_cnt: loadable down-counter that saturates at zero, with a zero flag.
module seq_gen_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] q,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? ld_val : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign q    = cnt_q;
    assign zero = (cnt_q == '0);
endmodule

// File: rtl/seq_gen.sv
// seq_gen: serial pattern burst generator; PAT_W-bit pattern sent MSB first,
// repeated reps times with an optional idle gap, closed by a one-cycle done pulse.
module seq_gen
    import seq_pkg::*;
#(
    parameter int             PAT_W    = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int             CNT_W    = 8,
    parameter int             GAP_W    = 4,
    parameter logic           IDLE_LVL = DEF_IDLE_LVL
) (
    input  logic     clk,
    input  logic     rst,
    seq_gen_if.slave bus
);
    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    state_t           state_q, state_d;
    logic             data_q, data_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic [GAP_W-1:0] gap_lat_q, gap_lat_d;
    logic             idx_ld, idx_dec, rl_ld, rl_dec, gc_ld, gc_dec;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic [CNT_W-1:0] rl_q;
    logic [GAP_W-1:0] gc_q;
    logic             idx_zero, rl_zero, gc_zero, rl_last, gc_last;

    seq_gen_cnt #(.W(IDX_W)) u_idx (.clk(clk), .rst(rst), .load(idx_ld), .dec(idx_dec),
                                    .ld_val(IDX_TOP), .q(idx_q), .zero(idx_zero));
    seq_gen_cnt #(.W(CNT_W)) u_rl (.clk(clk), .rst(rst), .load(rl_ld), .dec(rl_dec),
                                   .ld_val(bus.reps), .q(rl_q), .zero(rl_zero));
    seq_gen_cnt #(.W(GAP_W)) u_gc (.clk(clk), .rst(rst), .load(gc_ld), .dec(gc_dec),
                                   .ld_val(gap_lat_q), .q(gc_q), .zero(gc_zero));

    // Zero flags guard against a counter that is already empty, so a burst can never stall.
    assign rl_last = (rl_q == CNT_W'(1)) || rl_zero;
    assign gc_last = (gc_q == GAP_W'(1)) || gc_zero;

    always_comb begin
        state_d   = state_q;
        gap_lat_d = gap_lat_q;
        done_d    = 1'b0;
        idx_ld    = 1'b0;
        idx_dec   = 1'b0;
        rl_ld     = 1'b0;
        rl_dec    = 1'b0;
        gc_ld     = 1'b0;
        gc_dec    = 1'b0;
        case (state_q)
            IDLE: if (bus.start && !bus.abort) begin
                if (bus.reps != '0) begin
                    state_d   = SEND;
                    idx_ld    = 1'b1;
                    rl_ld     = 1'b1;
                    gap_lat_d = bus.gap;
                end else state_d = DONE;
            end
            SEND: if (bus.abort) state_d = IDLE;
                else if (idx_zero) begin
                    rl_dec = 1'b1;
                    if (rl_last) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (gap_lat_q != '0) begin
                        state_d = GAP;
                        gc_ld   = 1'b1;
                    end else idx_ld = 1'b1;
                end else idx_dec = 1'b1;
            GAP: if (bus.abort) state_d = IDLE;
                else if (gc_last) begin
                    state_d = SEND;
                    idx_ld  = 1'b1;
                end else gc_dec = 1'b1;
            // A zero-rep start enters DONE with done low and pulses on its second cycle.
            DONE: begin
                state_d = done_q ? IDLE : DONE;
                done_d  = !done_q;
            end
            default: state_d = IDLE;
        endcase
        idx_nxt = idx_ld ? IDX_TOP : idx_q - 1'b1;
        valid_d = (state_d == SEND);
        busy_d  = (state_d == SEND) || (state_d == GAP);
        data_d  = valid_d ? PATTERN[idx_nxt] : IDLE_LVL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gap_lat_q <= '0;
            data_q    <= IDLE_LVL;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_lat_q <= gap_lat_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.reps_left = rl_q;
endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern generator, the transmit-side companion to the `seq_check` sequence checker. On a start request it drives a fixed PAT_W-bit pattern onto a one-bit serial line, MSB first, for a programmable number of repetitions. An optional idle gap can be inserted between repetitions. A one-cycle done pulse closes each burst. It sits upstream of `seq_check`, as a traffic source for link bring-up and loopback test.

## Interface
Parameters:
- PAT_W, 4, pattern length in bits (≥2)
- PATTERN, 4'b0110, pattern transmitted MSB first
- CNT_W, 8, width of repetition count
- GAP_W, 4, width of inter-repetition gap count
- IDLE_LVL, 1'b1, line level driven when not sending pattern bits

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  burst request, sampled in IDLE only
- abort  in  1  terminate burst
- reps  in  CNT_W  repetitions per burst, latched on accepted start
- gap  in  GAP_W  idle bits between repetitions, latched on accepted start
- data  out  1  serial line
- valid  out  1  data carries a pattern bit
- busy  out  1  burst in progress
- done  out  1  one-cycle burst-complete pulse
- reps_left  out  CNT_W  repetitions not yet started, including the current one

## Operation
- All outputs are registered.
- Reset values: data=IDLE_LVL, valid=0, busy=0, done=0, reps_left=0, state=IDLE.
- States: IDLE, SEND, GAP, DONE.
- IDLE: data=IDLE_LVL, valid=0, busy=0.
  - start=1 and reps≠0: latch reps and gap, bit index=PAT_W-1, go to SEND.
  - start=1 and reps=0: go to DONE; no pattern bits are sent.
- SEND: data=PATTERN[idx], valid=1, busy=1. idx decrements each cycle.
  - When idx=0, reps_left decrements.
  - If it reaches 0, go to DONE.
  - Otherwise, if gap≠0, go to GAP for gap cycles.
  - Otherwise re-enter SEND at idx=PAT_W-1 with no idle cycle between repetitions.
- GAP: data=IDLE_LVL, valid=0, busy=1. After the latched gap count, go to SEND at idx=PAT_W-1.
- DONE: done=1, busy=0, valid=0, data=IDLE_LVL for exactly one cycle, then IDLE.
- start outside IDLE is ignored. reps and gap are not re-sampled mid-burst.
- abort in SEND or GAP: next state is IDLE, with valid=0, busy=0, data=IDLE_LVL. No done pulse. Any partial pattern is truncated.
- abort in IDLE or DONE has no effect, except that abort and start together in IDLE means start is ignored (abort wins).
- rst mid-burst returns all outputs to reset values immediately.
- Counter arithmetic is unsigned and never wraps:
  - reps_left stops at 0.
  - The gap counter is loaded with the gap value and counts down to 1.

## Timing
- Let E0 be the edge that samples an accepted start.
- During cycle E0+i, for i = 0..PAT_W-1, data=PATTERN[PAT_W-1-i].
- Start-to-first-bit latency: 1 edge.
- Each repetition occupies PAT_W cycles, followed by gap idle cycles. No gap follows the last repetition.
- done rises at edge E0 + reps·PAT_W + (reps−1)·gap and lasts 1 cycle.
- busy is high from E0 until that edge.
- Earliest next accepted start: sampled at the edge after done falls, i.e. in IDLE.
- reps=0: done rises at E0+1; busy never asserts.

## Structure
- Package seq_pkg contains:
  - state enum (IDLE, SEND, GAP, DONE)
  - default PATTERN constant, shared with the checker
  - IDLE_LVL constant
- One sub-module, seq_gen_cnt: a parameterized loadable down-counter with load, decrement enable and zero flag. It is instantiated three times, for bit index, reps_left and gap.
- The FSM and output registers live in seq_gen.

## Test plan
- Reset mid-burst: assert rst during SEND of reps=5 → data=1, valid=0, busy=0, done=0 in the same cycle; no done afterwards.
- Single repetition: reps=1, gap=0 → data 0,1,1,0 on 4 consecutive cycles after E0, valid=1 throughout; done at E0+4.
- Back-to-back, loopback into `seq_check`: reps=3, gap=0 → serial 011001100110; the checker's ind pulses 3 times; done at E0+12.
- Gap insertion: reps=2, gap=3 → 0110,1,1,1,0110 with valid low for the 3 gap cycles; done at E0+11; reps_left steps 2→1→0.
- Abort and ignore: abort in the second GAP cycle of reps=4, gap=2 → IDLE next cycle, no done. start held while busy is ignored. start with reps=0 → done at E0+1 with no valid cycles.
